// File: rtl/lc3_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// lc3_ctrl_pkg
// Shared definitions for the LC-3 pipeline controller:
//   - 4-bit opcode constants (IR[15:12])
//   - mem_state output encodings
//   - controller FSM state enum
//   - fill-counter / branch-stall constants
//   - opcode classification helpers
// -----------------------------------------------------------------------------
package lc3_ctrl_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;

  localparam logic [1:0] MEM_RD   = 2'd0;
  localparam logic [1:0] MEM_WR   = 2'd1;
  localparam logic [1:0] MEM_IND  = 2'd2;
  localparam logic [1:0] MEM_IDLE = 2'd3;

  // Pipeline fill saturates once every stage holds a valid instruction.
  localparam logic [2:0] FILL_MAX = 3'd4;
  // Branch stall lasts three cycles: the counter walks 2,1,0.
  localparam logic [1:0] BR_STALL_LAST = 2'd2;

  // State names carry an S_ prefix because MEM_IND is already the
  // mem_state code for an indirect-address read.
  typedef enum logic [2:0] {
    S_RUN,
    S_MEM_IND,
    S_MEM_READ,
    S_MEM_WRITE,
    S_BR_STALL
  } ctrl_state_e;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
  endfunction

  function automatic logic is_load_op(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
  endfunction

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI) ||
           (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
  endfunction

endpackage

// File: rtl/lc3_ctrl_hazard.sv
// -----------------------------------------------------------------------------
// lc3_ctrl_hazard
// Purely combinational forwarding detection between execute and decode.
// Ports:
//   IR           in  16  instruction in decode (consumer)
//   IR_Exec      in  16  instruction in execute (producer)
//   bypass_alu_1 out  1  ALU result -> SR1
//   bypass_alu_2 out  1  ALU result -> SR2
//   bypass_mem_1 out  1  load data  -> SR1
//   bypass_mem_2 out  1  load data  -> SR2
// Outputs are raw; the controller gates them with its state.
// -----------------------------------------------------------------------------
module lc3_ctrl_hazard
  import lc3_ctrl_pkg::*;
(
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic        bypass_mem_1,
  output logic        bypass_mem_2
);

  logic [3:0] dec_op;
  logic [3:0] exe_op;
  logic       sr1_hit;
  logic       sr2_hit;

  assign dec_op = IR[15:12];
  assign exe_op = IR_Exec[15:12];

  // SR1 lives in IR[8:6] for every consumer listed here.
  assign sr1_hit = (IR_Exec[11:9] == IR[8:6]) &&
                   ((dec_op == OP_ADD) || (dec_op == OP_AND) || (dec_op == OP_NOT) ||
                    (dec_op == OP_LDR) || (dec_op == OP_STR) || (dec_op == OP_JMP));

  // SR2 only exists in register-mode ADD/AND (IR[5]=0).
  assign sr2_hit = (IR_Exec[11:9] == IR[2:0]) && !IR[5] &&
                   ((dec_op == OP_ADD) || (dec_op == OP_AND));

  assign bypass_alu_1 = is_alu_op(exe_op)  && sr1_hit;
  assign bypass_alu_2 = is_alu_op(exe_op)  && sr2_hit;
  assign bypass_mem_1 = is_load_op(exe_op) && sr1_hit;
  assign bypass_mem_2 = is_load_op(exe_op) && sr2_hit;

  logic unused_bits;
  assign unused_bits = ^{IR[11:9], IR[4:3], IR_Exec[8:0]};

endmodule

// File: rtl/lc3_controller.sv
// -----------------------------------------------------------------------------
// lc3_controller
// Stall/enable controller for a five-stage LC-3 pipeline.
// Ports:
//   clock, reset (async, active-low)
//   complete_data, complete_instr      memory handshakes
//   IR, IR_Exec, IMem_dout, NZP, psr   instruction / condition inputs
//   enable_updatePC/fetch/decode/execute/writeback   stage enables
//   br_taken                           PC redirect
//   bypass_alu_1/2, bypass_mem_1/2     forwarding selects
//   mem_state                          0 rd, 1 wr, 2 indirect rd, 3 idle
// All outputs are combinational from registered state and current inputs.
// -----------------------------------------------------------------------------
module lc3_controller
  import lc3_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_data,
  input  logic        complete_instr,
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic [15:0] IMem_dout,
  input  logic [2:0]  NZP,
  input  logic [2:0]  psr,
  output logic        enable_updatePC,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        br_taken,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic        bypass_mem_1,
  output logic        bypass_mem_2,
  output logic [1:0]  mem_state
);

  ctrl_state_e state_q, state_d;
  logic [2:0]  fill_q, fill_d;
  logic [1:0]  stall_cnt_q, stall_cnt_d;
  logic        br_pend_q, br_pend_d;   // branch seen while a memory op won
  logic        ind_wr_q, ind_wr_d;     // indirect op is STI (else LDI)

  logic [3:0]  exe_op;
  logic [3:0]  fetch_op;
  logic        mem_go;
  logic        br_go;
  logic        raw_alu_1, raw_alu_2, raw_mem_1, raw_mem_2;
  logic        bypass_ok;

  assign exe_op   = IR_Exec[15:12];
  assign fetch_op = IMem_dout[15:12];

  lc3_ctrl_hazard u_hazard (
    .IR           (IR),
    .IR_Exec      (IR_Exec),
    .bypass_alu_1 (raw_alu_1),
    .bypass_alu_2 (raw_alu_2),
    .bypass_mem_1 (raw_mem_1),
    .bypass_mem_2 (raw_mem_2)
  );

  // Outputs are also gated by reset so they drop in the same cycle it asserts.
  always_comb begin
    enable_updatePC  = 1'b0;
    enable_fetch     = 1'b0;
    enable_decode    = 1'b0;
    enable_execute   = 1'b0;
    enable_writeback = 1'b0;
    mem_state        = MEM_IDLE;
    br_taken         = 1'b0;
    if (reset) begin
      case (state_q)
        S_RUN: begin
          enable_updatePC  = (fill_q >= 3'd1);
          enable_fetch     = (fill_q >= 3'd1);
          enable_decode    = (fill_q >= 3'd2);
          enable_execute   = (fill_q >= 3'd3);
          enable_writeback = (fill_q >= 3'd4);
        end
        S_BR_STALL: begin
          enable_decode    = 1'b1;
          enable_execute   = 1'b1;
          enable_writeback = 1'b1;
        end
        S_MEM_IND:   mem_state = MEM_IND;
        S_MEM_READ: begin
          mem_state        = MEM_RD;
          enable_writeback = complete_data;
        end
        S_MEM_WRITE: mem_state = MEM_WR;
        default: ;
      endcase
      br_taken = enable_execute &&
                 ((exe_op == OP_JMP) || ((exe_op == OP_BR) && (|(NZP & psr))));
      // During the stall the PC only moves to load the resolved target.
      if (state_q == S_BR_STALL) begin
        enable_updatePC = br_taken;
      end
    end
  end

  assign bypass_ok    = reset && (state_q == S_RUN);
  assign bypass_alu_1 = bypass_ok && raw_alu_1;
  assign bypass_alu_2 = bypass_ok && raw_alu_2;
  assign bypass_mem_1 = bypass_ok && raw_mem_1;
  assign bypass_mem_2 = bypass_ok && raw_mem_2;

  assign mem_go = enable_execute && is_mem_op(exe_op);
  // A branch deferred behind a memory op re-triggers on return to RUN.
  assign br_go  = (enable_fetch && complete_instr &&
                   ((fetch_op == OP_BR) || (fetch_op == OP_JMP))) || br_pend_q;

  always_comb begin
    state_d     = state_q;
    fill_d      = (fill_q == FILL_MAX) ? fill_q : fill_q + 3'd1;
    stall_cnt_d = stall_cnt_q;
    br_pend_d   = br_pend_q;
    ind_wr_d    = ind_wr_q;
    case (state_q)
      S_RUN: begin
        if (mem_go) begin
          br_pend_d = br_go;
          ind_wr_d  = (exe_op == OP_STI);
          if ((exe_op == OP_LD) || (exe_op == OP_LDR)) begin
            state_d = S_MEM_READ;
          end else if ((exe_op == OP_ST) || (exe_op == OP_STR)) begin
            state_d = S_MEM_WRITE;
          end else begin
            state_d = S_MEM_IND;
          end
        end else if (br_go) begin
          state_d     = S_BR_STALL;
          stall_cnt_d = BR_STALL_LAST;
          br_pend_d   = 1'b0;
        end
      end
      S_MEM_IND: begin
        if (complete_data) begin
          state_d = ind_wr_q ? S_MEM_WRITE : S_MEM_READ;
        end
      end
      S_MEM_READ, S_MEM_WRITE: begin
        if (complete_data) begin
          state_d = S_RUN;
        end
      end
      S_BR_STALL: begin
        if (stall_cnt_q == 2'd0) begin
          state_d = S_RUN;
        end else begin
          stall_cnt_d = stall_cnt_q - 2'd1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_RUN;
      fill_q      <= 3'd0;
      stall_cnt_q <= 2'd0;
      br_pend_q   <= 1'b0;
      ind_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      stall_cnt_q <= stall_cnt_d;
      br_pend_q   <= br_pend_d;
      ind_wr_q    <= ind_wr_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^IMem_dout[11:0];

endmodule

// File: tb/tb_lc3_controller.sv
// -----------------------------------------------------------------------------
// tb_lc3_controller
// Directed scenarios followed by randomized cycles, all checked against a
// behavioural model: fill as a cycle count, memory ops as a queue of phases,
// branch stall as a remaining-cycle count.
// -----------------------------------------------------------------------------
module tb_lc3_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        complete_data, complete_instr;
  logic [15:0] IR, IR_Exec, IMem_dout;
  logic [2:0]  NZP, psr;
  logic        enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback;
  logic        br_taken, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
  logic [1:0]  mem_state;

  lc3_controller dut (
    .clock            (clock),
    .reset            (reset),
    .complete_data    (complete_data),
    .complete_instr   (complete_instr),
    .IR               (IR),
    .IR_Exec          (IR_Exec),
    .IMem_dout        (IMem_dout),
    .NZP              (NZP),
    .psr              (psr),
    .enable_updatePC  (enable_updatePC),
    .enable_fetch     (enable_fetch),
    .enable_decode    (enable_decode),
    .enable_execute   (enable_execute),
    .enable_writeback (enable_writeback),
    .br_taken         (br_taken),
    .bypass_alu_1     (bypass_alu_1),
    .bypass_alu_2     (bypass_alu_2),
    .bypass_mem_1     (bypass_mem_1),
    .bypass_mem_2     (bypass_mem_2),
    .mem_state        (mem_state)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state
  int m_cyc;        // cycles since reset release
  int m_memq[$];    // pending memory phases: 0 read, 1 write, 2 indirect
  int m_stall;      // branch-stall cycles remaining
  bit m_pend;       // branch deferred behind a memory op

  // Expected outputs
  logic e_upc, e_fetch, e_dec, e_exe, e_wb, e_br, e_a1, e_a2, e_m1, e_m2;
  logic [1:0] e_ms;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_cyc   = 0;
    m_memq  = {};
    m_stall = 0;
    m_pend  = 0;
  endtask

  task automatic model_expect();
    int  f, xo, io;
    bit  x_alu, x_ld, h1, h2;
    e_upc = 0; e_fetch = 0; e_dec = 0; e_exe = 0; e_wb = 0; e_br = 0;
    e_a1 = 0; e_a2 = 0; e_m1 = 0; e_m2 = 0; e_ms = 2'd3;
    if (!reset) return;
    f  = (m_cyc > 4) ? 4 : m_cyc;
    xo = int'(IR_Exec[15:12]);
    io = int'(IR[15:12]);
    if (m_memq.size() > 0) begin
      e_ms = 2'(m_memq[0]);
      e_wb = (m_memq[0] == 0) && complete_data;
    end else if (m_stall > 0) begin
      e_dec = 1; e_exe = 1; e_wb = 1;
    end else begin
      e_upc = (f >= 1); e_fetch = (f >= 1); e_dec = (f >= 2);
      e_exe = (f >= 3); e_wb = (f >= 4);
      x_alu = xo inside {1, 5, 9};
      x_ld  = xo inside {2, 6, 10};
      h1 = (IR_Exec[11:9] == IR[8:6]) && (io inside {1, 5, 9, 6, 7, 12});
      h2 = (IR_Exec[11:9] == IR[2:0]) && (io inside {1, 5}) && !IR[5];
      e_a1 = x_alu && h1; e_a2 = x_alu && h2;
      e_m1 = x_ld && h1;  e_m2 = x_ld && h2;
    end
    e_br = e_exe && ((xo == 12) || ((xo == 0) && ((NZP & psr) != 3'd0)));
    if (m_stall > 0) e_upc = e_br;
  endtask

  task automatic model_advance();
    int xo, fo;
    bit mem_go, br_go;
    if (!reset) begin
      model_clear();
      return;
    end
    xo = int'(IR_Exec[15:12]);
    fo = int'(IMem_dout[15:12]);
    if (m_memq.size() > 0) begin
      if (complete_data) void'(m_memq.pop_front());
    end else if (m_stall > 0) begin
      m_stall--;
    end else begin
      mem_go = e_exe && (xo inside {2, 3, 6, 7, 10, 11});
      br_go  = (e_fetch && complete_instr && (fo inside {0, 12})) || m_pend;
      if (mem_go) begin
        case (xo)
          2, 6:    m_memq = {0};
          3, 7:    m_memq = {1};
          10:      m_memq = {2, 0};
          default: m_memq = {2, 1};
        endcase
        m_pend = br_go;
      end else if (br_go) begin
        m_stall = 3;
        m_pend  = 0;
      end
    end
    m_cyc++;
  endtask

  // Inputs are set at the negedge before calling; this checks then clocks.
  task automatic step();
    #1;
    if (!reset) model_clear();
    model_expect();
    check_eq("upc",   enable_updatePC,  e_upc);
    check_eq("fetch", enable_fetch,     e_fetch);
    check_eq("dec",   enable_decode,    e_dec);
    check_eq("exe",   enable_execute,   e_exe);
    check_eq("wb",    enable_writeback, e_wb);
    check_eq("br",    br_taken,         e_br);
    check_eq("alu1",  bypass_alu_1,     e_a1);
    check_eq("alu2",  bypass_alu_2,     e_a2);
    check_eq("mem1",  bypass_mem_1,     e_m1);
    check_eq("mem2",  bypass_mem_2,     e_m2);
    check_eq("mst",   mem_state,        e_ms);
    model_advance();
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic idle_inputs();
    complete_data = 0; complete_instr = 0;
    IR = 16'h1000; IR_Exec = 16'h1000; IMem_dout = 16'h1000;
    NZP = 3'b000; psr = 3'b000;
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    model_clear();
    @(negedge clock);
    step();

    // Fill sequence after reset release
    reset = 1;
    #1;
    check_eq("fill0_en", {enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback}, 5'b00000);
    check_eq("fill0_ms", mem_state, 2'd3);
    for (int i = 0; i < 6; i++) step();
    check_eq("fill4_en", {enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback}, 5'b11111);
    $display("txn fill: enables ramped");

    // LDR with complete_data on the third memory cycle
    IR_Exec = 16'h6000; step();
    step(); step();
    complete_data = 1;
    #1;
    check_eq("ldr_ms", mem_state, 2'd0);
    check_eq("ldr_wb", enable_writeback, 1'b1);
    check_eq("ldr_fetch", enable_fetch, 1'b0);
    step();
    complete_data = 0; IR_Exec = 16'h1000;
    #1; check_eq("ldr_done_ms", mem_state, 2'd3);
    step();
    $display("txn ldr: read completed");

    // STI: indirect read then write
    IR_Exec = 16'hB000; step();
    #1; check_eq("sti_ind_ms", mem_state, 2'd2);
    step();
    complete_data = 1; step();
    #1; check_eq("sti_wr_ms", mem_state, 2'd1);
    step();
    complete_data = 0; IR_Exec = 16'h1000;
    #1; check_eq("sti_done_ms", mem_state, 2'd3);
    step();
    $display("txn sti: indirect then write");

    // BRnzp fetch -> stall, resolve with psr=Z
    IMem_dout = 16'h0E02; complete_instr = 1; step();
    complete_instr = 0; IMem_dout = 16'h1000;
    #1; check_eq("bs_fetch0", enable_fetch, 1'b0);
    step();
    IR_Exec = 16'h0E02; NZP = 3'b111; psr = 3'b010;
    #1;
    check_eq("bs_taken", br_taken, 1'b1);
    check_eq("bs_upc", enable_updatePC, 1'b1);
    step();
    IR_Exec = 16'h1000; NZP = 3'b000;
    step();
    #1; check_eq("bs_resume", enable_fetch, 1'b1);
    step();
    $display("txn br: stall and redirect");

    // Forwarding
    IR_Exec = 16'h1261; IR = 16'h1441;
    #1;
    check_eq("fw_alu1", bypass_alu_1, 1'b1);
    check_eq("fw_alu2", bypass_alu_2, 1'b1);
    step();
    IR_Exec = 16'h2200;
    #1;
    check_eq("fw_mem1", bypass_mem_1, 1'b1);
    check_eq("fw_mem2", bypass_mem_2, 1'b1);
    step();
    #1; check_eq("fw_gated", bypass_mem_1, 1'b0);
    complete_data = 1; step();
    complete_data = 0; IR_Exec = 16'h1000; IR = 16'h1000; step();
    $display("txn fwd: bypass selects");

    // Memory and branch triggering together: memory wins, branch follows
    IR_Exec = 16'h2000; IMem_dout = 16'h0000; complete_instr = 1; step();
    complete_instr = 0; IMem_dout = 16'h1000; complete_data = 1; step();
    complete_data = 0; IR_Exec = 16'h1000;
    #1; check_eq("pri_run_fetch", enable_fetch, 1'b1);
    step();
    #1; check_eq("pri_stall_fetch", enable_fetch, 1'b0);
    for (int i = 0; i < 4; i++) step();
    $display("txn prio: deferred branch stall");

    // Reset during MEM_READ; late complete_data ignored
    IR_Exec = 16'h6000; step();
    IR_Exec = 16'h1000; step();
    reset = 0; complete_data = 1;
    #1;
    check_eq("rst_ms", mem_state, 2'd3);
    check_eq("rst_wb", enable_writeback, 1'b0);
    step();
    reset = 1; step();
    complete_data = 0;
    for (int i = 0; i < 5; i++) step();
    $display("txn rst: abandon read");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(0, 249) != 0);
      complete_data  = ($urandom_range(0, 2) == 0);
      complete_instr = $urandom_range(0, 1) == 1;
      IR             = 16'($urandom);
      IR_Exec        = 16'($urandom);
      IMem_dout      = 16'($urandom);
      NZP            = IR_Exec[11:9];
      psr            = 3'($urandom);
      step();
    end
    $display("txn random: 3000 cycles");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lc3_controller.md
LC3_CONTROLLER -- requirements
Module: lc3_controller

Interface
REQ-001 One clock, clock; reset is asynchronous and active-low, port reset; all state SHALL use posedge clock.
REQ-002 clock  input  1  pipeline clock.
REQ-003 reset  input  1  async active-low reset.
REQ-004 complete_data  input  1  data-memory access done, 1-cycle pulse.
REQ-005 complete_instr  input  1  instruction-memory fetch done.
REQ-006 IR  input  16  instruction in decode.
REQ-007 IR_Exec  input  16  instruction in execute.
REQ-008 IMem_dout  input  16  instruction being fetched.
REQ-009 NZP  input  3  branch condition field of IR_Exec.
REQ-010 psr  input  3  current condition codes {N,Z,P}.
REQ-011 enable_updatePC  output  1  PC update enable.
REQ-012 enable_fetch  output  1  fetch stage enable.
REQ-013 enable_decode  output  1  decode stage enable.
REQ-014 enable_execute  output  1  execute stage enable.
REQ-015 enable_writeback  output  1  writeback enable.
REQ-016 br_taken  output  1  redirect PC to branch target.
REQ-017 bypass_alu_1  output  1  forward ALU result to SR1.
REQ-018 bypass_alu_2  output  1  forward ALU result to SR2.
REQ-019 bypass_mem_1  output  1  forward load data to SR1.
REQ-020 bypass_mem_2  output  1  forward load data to SR2.
REQ-021 mem_state  output  2  0 read, 1 write, 2 indirect-address read, 3 idle.

Function
REQ-022 FSM states SHALL be RUN, MEM_IND, MEM_READ, MEM_WRITE, BR_STALL; reset state RUN.
REQ-023 Fill counter (0..4) after reset SHALL enable updatePC/fetch at fill>=1, decode >=2, execute >=3, writeback >=4, saturating at 4.
REQ-024 RUN with fill=4: all five enables 1, mem_state 3.
REQ-025 RUN, enable_execute=1, IR_Exec[15:12] LD(0010)/LDR(0110) -> MEM_READ; LDI(1010)/STI(1011) -> MEM_IND; ST(0011)/STR(0111) -> MEM_WRITE.
REQ-026 In every MEM_* state all five enables SHALL be 0, except enable_writeback=1 in MEM_READ during the cycle complete_data=1.
REQ-027 MEM_IND: mem_state 2; on complete_data -> MEM_READ if LDI, MEM_WRITE if STI.
REQ-028 MEM_READ: mem_state 0; MEM_WRITE: mem_state 1; each on complete_data -> RUN; without complete_data stay indefinitely.
REQ-029 RUN, enable_fetch=1, complete_instr=1, IMem_dout[15:12] BR(0000)/JMP(1100) -> BR_STALL with 3-cycle countdown.
REQ-030 BR_STALL: enable_updatePC and enable_fetch 0, others 1; count 0 -> RUN; updatePC re-enables the cycle br_taken resolves.
REQ-031 br_taken SHALL be 1 exactly when IR_Exec is JMP, or BR with |(NZP & psr), and enable_execute=1; otherwise 0.
REQ-032 Memory entry SHALL take priority over branch entry when both trigger in the same cycle; branch stall then resumes after return to RUN.
REQ-033 bypass_alu_1 = IR_Exec in {ADD 0001, AND 0101, NOT 1001} and IR_Exec[11:9]==IR[8:6] and IR in {ADD, AND, NOT, LDR, STR, JMP}.
REQ-034 bypass_alu_2 = IR_Exec ALU op and IR_Exec[11:9]==IR[2:0] and IR in {ADD, AND} with IR[5]=0; bypass_mem_1/2 identical with IR_Exec in {LD, LDR, LDI}.
REQ-035 All bypass outputs SHALL be forced 0 outside RUN; all outputs combinational from state and inputs, zero added latency.

Reset
REQ-036 reset=0 SHALL immediately force enables 0, br_taken 0, bypasses 0, mem_state 3, state RUN, fill 0, stall count 0.
REQ-037 Reset asserted mid-MEM_* or mid-BR_STALL SHALL abandon the operation; the pending complete_data is ignored.

Structure
REQ-038 Package lc3_ctrl_pkg SHALL hold opcode constants, state enum and mem_state encodings (MEM_RD=0, MEM_WR=1, MEM_IND=2, MEM_IDLE=3).
REQ-039 Forwarding logic SHALL be sub-module lc3_ctrl_hazard (IR, IR_Exec in; four bypass outputs).

Verification
REQ-040 Release reset, NOP stream -> enables rise at cycles 1,1,2,3,4; mem_state 3 throughout.
REQ-041 IR_Exec=LDR, complete_data at 3rd cycle -> mem_state 0 for 3 cycles, enables 0, writeback 1 on last cycle, then RUN.
REQ-042 IR_Exec=STI -> mem_state 2 then 1, each exit on complete_data, then 3.
REQ-043 IMem_dout=0x0E02 (BRnzp) -> fetch/updatePC 0 for 3 cycles; psr=010 at execute -> br_taken 1.
REQ-044 IR_Exec=0x1261 (ADD R1), IR=0x1441 (ADD R2,R1,R1) -> bypass_alu_1=1, bypass_alu_2=1.
REQ-045 Reset pulse during MEM_READ -> all outputs at reset values within same cycle; late complete_data has no effect.
